// File: rtl/cajero_param_if.sv
// cajero_param_if: card/PIN/transaction signal bundle between the ATM controller and its host.
interface cajero_param_if #(
    parameter int PIN_DIGITS = 4,
    parameter int MONTO_W    = 32,
    parameter int BAL_W      = 64
);
    logic                    Tarjeta_recibida;
    logic                    Fin_sesion;
    logic [4*PIN_DIGITS-1:0] PIN;
    logic [3:0]              Digito;
    logic                    Digito_STB;
    logic                    Tipo_trans;
    logic [MONTO_W-1:0]      Monto;
    logic                    Monto_STB;
    logic                    Balance_actualizado;
    logic                    Entregar_dinero;
    logic                    Fondos_insuficientes;
    logic                    Limite_excedido;
    logic                    PIN_incorrecto;
    logic                    Advertencia;
    logic                    Bloqueo;
    logic [BAL_W-1:0]        Balance;
    logic [1:0]              Estado;
    modport master (
        output Tarjeta_recibida, Fin_sesion, PIN, Digito, Digito_STB, Tipo_trans, Monto, Monto_STB,
        input  Balance_actualizado, Entregar_dinero, Fondos_insuficientes, Limite_excedido,
               PIN_incorrecto, Advertencia, Bloqueo, Balance, Estado
    );
    modport slave (
        input  Tarjeta_recibida, Fin_sesion, PIN, Digito, Digito_STB, Tipo_trans, Monto, Monto_STB,
        output Balance_actualizado, Entregar_dinero, Fondos_insuficientes, Limite_excedido,
               PIN_incorrecto, Advertencia, Bloqueo, Balance, Estado
    );
endinterface

// File: rtl/cajero_param.sv
// cajero_param: ATM controller with PIN entry, attempt lockout, deposits/withdrawals,
// per-session withdrawal limit and idle timeout.
module cajero_param #(
    parameter int PIN_DIGITS    = 4,
    parameter int MONTO_W       = 32,
    parameter int BAL_W         = 64,
    parameter int ADV_INTENTOS  = 2,
    parameter int MAX_INTENTOS  = 3,
    parameter int LIMITE_RETIRO = 10000,
    parameter int TIMEOUT_CYC   = 1000
) (
    input logic           CLK,
    input logic           Reset,
    cajero_param_if.slave bus
);
    typedef enum logic [1:0] {ESPERA_TARJETA, INGRESO_PIN, SESION, BLOQUEADO} estado_t;
    localparam int DW = $clog2(PIN_DIGITS + 1);
    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BAL_W:0] LIM = (BAL_W + 1)'(LIMITE_RETIRO);

    estado_t                 r_estado, w_estado;
    logic [4*PIN_DIGITS-1:0] r_shift, w_shift;
    logic [DW-1:0]           r_dig, w_dig;
    logic                    r_cmp, w_cmp;
    logic [IW-1:0]           r_int, w_int;
    logic                    r_adv, w_adv, r_bloq, w_bloq;
    logic [BAL_W-1:0]        r_bal, w_bal, r_ret, w_ret;
    logic [TW-1:0]           r_idle, w_idle;
    logic                    r_bact, w_bact, r_ent, w_ent, r_fond, w_fond, r_lim, w_lim, r_pinc, w_pinc;
    logic [BAL_W-1:0]        w_m;
    logic [BAL_W:0]          w_sum, w_rsum;
    logic [IW-1:0]           w_int_inc;
    logic                    w_tout;

    assign w_m       = BAL_W'(bus.Monto);
    assign w_sum     = {1'b0, r_bal} + {1'b0, w_m};
    assign w_rsum    = {1'b0, r_ret} + {1'b0, w_m};
    assign w_int_inc = r_int + 1'b1;
    assign w_tout    = r_idle == TW'(TIMEOUT_CYC - 1);

    always_comb begin
        w_estado = r_estado;
        w_shift  = r_shift;
        w_dig    = r_dig;
        w_cmp    = 1'b0;
        w_int    = r_int;
        w_adv    = r_adv;
        w_bloq   = r_bloq;
        w_bal    = r_bal;
        w_ret    = r_ret;
        w_idle   = r_idle + 1'b1;
        w_bact   = 1'b0;
        w_ent    = 1'b0;
        w_fond   = 1'b0;
        w_lim    = 1'b0;
        w_pinc   = 1'b0;
        case (r_estado)
            ESPERA_TARJETA: begin
                w_idle  = '0;
                w_shift = '0;
                w_dig   = '0;
                if (bus.Tarjeta_recibida)
                    w_estado = r_bloq ? BLOQUEADO : INGRESO_PIN;
            end
            INGRESO_PIN: begin
                if (r_cmp) begin
                    w_dig = '0;
                    if (r_shift == bus.PIN) begin
                        w_estado = SESION;
                        w_int    = '0;
                        w_adv    = 1'b0;
                        w_idle   = '0;
                    end else begin
                        w_pinc = 1'b1;
                        w_int  = w_int_inc;
                        w_adv  = r_adv | (w_int_inc >= IW'(ADV_INTENTOS));
                        if (w_int_inc >= IW'(MAX_INTENTOS)) begin
                            w_bloq   = 1'b1;
                            w_estado = BLOQUEADO;
                        end
                    end
                end else if (bus.Digito_STB) begin
                    w_shift = (4*PIN_DIGITS)'({r_shift, bus.Digito});
                    w_dig   = r_dig + 1'b1;
                    w_cmp   = r_dig == DW'(PIN_DIGITS - 1);
                    w_idle  = '0;
                end else if (w_tout) begin
                    w_estado = ESPERA_TARJETA;
                    w_dig    = '0;
                end
            end
            SESION: begin
                if (bus.Monto_STB && bus.Monto != '0) begin
                    w_idle = '0;
                    if (!bus.Tipo_trans) begin
                        w_bal  = w_sum[BAL_W] ? '1 : w_sum[BAL_W-1:0];
                        w_bact = 1'b1;
                    end else if (w_m > r_bal) begin
                        w_fond = 1'b1;
                    end else if (w_rsum > LIM) begin
                        w_lim = 1'b1;
                    end else begin
                        w_bal  = r_bal - w_m;
                        w_ret  = w_rsum[BAL_W-1:0];
                        w_bact = 1'b1;
                        w_ent  = 1'b1;
                    end
                end else if (w_tout) begin
                    w_estado = ESPERA_TARJETA;
                end
            end
            default: w_idle = '0;
        endcase
        // The ending session's own transaction above already used the old running total.
        if ((r_estado == INGRESO_PIN || r_estado == SESION) && bus.Fin_sesion && w_estado != BLOQUEADO) begin
            w_estado = ESPERA_TARJETA;
            w_ret    = '0;
            w_cmp    = 1'b0;
        end
        if (w_estado != r_estado) w_idle = '0;
        if (w_estado == ESPERA_TARJETA && r_estado == SESION) w_ret = '0;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_estado <= ESPERA_TARJETA;
            r_shift  <= '0;
            r_dig    <= '0;
            r_cmp    <= 1'b0;
            r_int    <= '0;
            r_adv    <= 1'b0;
            r_bloq   <= 1'b0;
            r_bal    <= '0;
            r_ret    <= '0;
            r_idle   <= '0;
            r_bact   <= 1'b0;
            r_ent    <= 1'b0;
            r_fond   <= 1'b0;
            r_lim    <= 1'b0;
            r_pinc   <= 1'b0;
        end else begin
            r_estado <= w_estado;
            r_shift  <= w_shift;
            r_dig    <= w_dig;
            r_cmp    <= w_cmp;
            r_int    <= w_int;
            r_adv    <= w_adv;
            r_bloq   <= w_bloq;
            r_bal    <= w_bal;
            r_ret    <= w_ret;
            r_idle   <= w_idle;
            r_bact   <= w_bact;
            r_ent    <= w_ent;
            r_fond   <= w_fond;
            r_lim    <= w_lim;
            r_pinc   <= w_pinc;
        end
    end

    assign bus.Estado               = r_estado;
    assign bus.Balance              = r_bal;
    assign bus.Advertencia          = r_adv;
    assign bus.Bloqueo              = r_bloq;
    assign bus.Balance_actualizado  = r_bact;
    assign bus.Entregar_dinero      = r_ent;
    assign bus.Fondos_insuficientes = r_fond;
    assign bus.Limite_excedido      = r_lim;
    assign bus.PIN_incorrecto       = r_pinc;
endmodule

// File: tb/tb_cajero_param.sv
// tb_cajero_param: scenario tasks with a transaction scoreboard for cajero_param.
module tb_cajero_param;
    localparam int PD = 4, MW = 32, BW = 64, ADV = 2, MAXI = 3, LIM = 10000, TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0, n_ent = 0, n_pinc = 0;

    typedef struct packed {
        logic [3:0]    p;
        logic [BW-1:0] bal;
    } exp_t;
    exp_t sb[$];
    logic [BW-1:0] m_bal = '0, m_ret = '0;

    cajero_param_if #(.PIN_DIGITS(PD), .MONTO_W(MW), .BAL_W(BW)) bus();

    cajero_param #(
        .PIN_DIGITS(PD), .MONTO_W(MW), .BAL_W(BW), .ADV_INTENTOS(ADV),
        .MAX_INTENTOS(MAXI), .LIMITE_RETIRO(LIM), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Result pulses are matched against the scoreboard in the order transactions were issued.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] p;
        p = {bus.Balance_actualizado, bus.Entregar_dinero, bus.Fondos_insuficientes, bus.Limite_excedido};
        if (bus.Entregar_dinero) n_ent++;
        if (bus.PIN_incorrecto) n_pinc++;
        if (p != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got pulses=%b balance=%0d, required no pulse", p, bus.Balance);
            end else begin
                e = sb.pop_front();
                if ({p, bus.Balance} !== e) begin
                    errors++;
                    $display("FAIL tx_result: got pulses=%b balance=%0d, required pulses=%b balance=%0d",
                             p, bus.Balance, e.p, e.bal);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic insert_card;
        bus.Tarjeta_recibida = 1'b1;
        tick;
        bus.Tarjeta_recibida = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) begin
            bus.Digito     = p[4*i+:4];
            bus.Digito_STB = 1'b1;
            tick;
        end
        bus.Digito_STB = 1'b0;
    endtask

    task automatic open_session;
        insert_card;
        enter_pin(16'h1234);
        tick;
    endtask

    task automatic end_session;
        bus.Fin_sesion = 1'b1;
        tick;
        bus.Fin_sesion = 1'b0;
        m_ret = '0;
    endtask

    task automatic do_tx(input logic tipo, input logic [MW-1:0] m, input logic fin);
        exp_t e;
        if (m != '0) begin
            if (!tipo) begin
                m_bal = (m_bal + BW'(m) < m_bal) ? '1 : m_bal + BW'(m);
                e.p = 4'b1000;
            end else if (BW'(m) > m_bal) begin
                e.p = 4'b0010;
            end else if (m_ret + BW'(m) > BW'(LIM)) begin
                e.p = 4'b0001;
            end else begin
                m_bal = m_bal - BW'(m);
                m_ret = m_ret + BW'(m);
                e.p = 4'b1100;
            end
            e.bal = m_bal;
            sb.push_back(e);
        end
        if (fin) m_ret = '0;
        bus.Tipo_trans = tipo;
        bus.Monto      = m;
        bus.Monto_STB  = 1'b1;
        bus.Fin_sesion = fin;
        tick;
        bus.Monto_STB  = 1'b0;
        bus.Fin_sesion = 1'b0;
    endtask

    task automatic drain;
        tick;
        tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding results, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.Tarjeta_recibida = 1'b1;
        tick;
        tick;
        bus.Tarjeta_recibida = 1'b0;
        checks++;
        if (bus.Estado !== 2'd0 || bus.Balance !== '0) begin
            errors++;
            $display("FAIL reset_state: got estado=%0d balance=%0d, required 0 0", bus.Estado, bus.Balance);
        end
        checks++;
        if ({bus.Advertencia, bus.Bloqueo, bus.PIN_incorrecto, bus.Balance_actualizado,
             bus.Entregar_dinero, bus.Fondos_insuficientes, bus.Limite_excedido} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero flag outputs, required all 0");
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_pin_ok;
        insert_card;
        checks++;
        if (bus.Estado !== 2'd1) begin
            errors++;
            $display("FAIL card_in: got estado=%0d, required 1", bus.Estado);
        end
        enter_pin(16'h1234);
        checks++;
        if (bus.Estado !== 2'd1) begin
            errors++;
            $display("FAIL pin_cmp_wait: got estado=%0d, required 1", bus.Estado);
        end
        tick;
        checks++;
        if (bus.Estado !== 2'd2 || n_pinc != 0) begin
            errors++;
            $display("FAIL pin_ok: got estado=%0d pin_incorrecto_pulses=%0d, required 2 0", bus.Estado, n_pinc);
        end
        do_tx(1'b0, 500, 1'b0);
        do_tx(1'b1, 200, 1'b0);
        do_tx(1'b1, 400, 1'b0);
        drain;
        checks++;
        if (bus.Balance !== 64'd300 || n_ent != 1) begin
            errors++;
            $display("FAIL dep_wd: got balance=%0d entregar_pulses=%0d, required 300 1", bus.Balance, n_ent);
        end
        end_session;
        checks++;
        if (bus.Estado !== 2'd0) begin
            errors++;
            $display("FAIL fin_sesion: got estado=%0d, required 0", bus.Estado);
        end
    endtask

    task automatic test_limit;
        open_session;
        do_tx(1'b0, 19700, 1'b0);
        do_tx(1'b1, 6000, 1'b0);
        do_tx(1'b1, 5000, 1'b0);
        drain;
        end_session;
        open_session;
        do_tx(1'b1, 5000, 1'b0);
        drain;
        checks++;
        if (bus.Balance !== 64'd9000) begin
            errors++;
            $display("FAIL limit_new_session: got balance=%0d, required 9000", bus.Balance);
        end
        end_session;
    endtask

    task automatic test_back_to_back;
        open_session;
        do_tx(1'b0, 100, 1'b0);
        do_tx(1'b1, 50, 1'b0);
        do_tx(1'b1, 100000, 1'b0);
        do_tx(1'b0, 1, 1'b0);
        drain;
        checks++;
        if (bus.Balance !== 64'd9051) begin
            errors++;
            $display("FAIL back_to_back: got balance=%0d, required 9051", bus.Balance);
        end
        do_tx(1'b1, 0, 1'b0);
        bus.Digito_STB = 1'b1;
        tick;
        bus.Digito_STB = 1'b0;
        drain;
        checks++;
        if (bus.Estado !== 2'd2) begin
            errors++;
            $display("FAIL digit_in_session: got estado=%0d, required 2", bus.Estado);
        end
        do_tx(1'b1, 20, 1'b1);
        checks++;
        if (bus.Estado !== 2'd0) begin
            errors++;
            $display("FAIL fin_with_tx: got estado=%0d, required 0", bus.Estado);
        end
        drain;
        bus.Monto = 100;
        bus.Tipo_trans = 1'b0;
        bus.Monto_STB = 1'b1;
        tick;
        bus.Monto_STB = 1'b0;
        drain;
        checks++;
        if (bus.Balance !== 64'd9031 || bus.Estado !== 2'd0) begin
            errors++;
            $display("FAIL ignore_outside: got balance=%0d estado=%0d, required 9031 0", bus.Balance, bus.Estado);
        end
    endtask

    task automatic test_timeout;
        open_session;
        repeat (TO - 1) tick;
        checks++;
        if (bus.Estado !== 2'd2) begin
            errors++;
            $display("FAIL timeout_early_ses: got estado=%0d, required 2", bus.Estado);
        end
        tick;
        checks++;
        if (bus.Estado !== 2'd0) begin
            errors++;
            $display("FAIL timeout_ses: got estado=%0d, required 0", bus.Estado);
        end
        insert_card;
        bus.Digito = 4'd1;
        bus.Digito_STB = 1'b1;
        tick;
        bus.Digito = 4'd2;
        tick;
        bus.Digito_STB = 1'b0;
        repeat (TO - 1) tick;
        checks++;
        if (bus.Estado !== 2'd1) begin
            errors++;
            $display("FAIL timeout_early_pin: got estado=%0d, required 1", bus.Estado);
        end
        tick;
        checks++;
        if (bus.Estado !== 2'd0) begin
            errors++;
            $display("FAIL timeout_pin: got estado=%0d, required 0", bus.Estado);
        end
        open_session;
        checks++;
        if (bus.Estado !== 2'd2 || n_pinc != 0) begin
            errors++;
            $display("FAIL partial_discard: got estado=%0d pin_incorrecto_pulses=%0d, required 2 0", bus.Estado, n_pinc);
        end
        end_session;
    endtask

    task automatic test_lock;
        int base;
        base = n_pinc;
        insert_card;
        enter_pin(16'h5555);
        tick;
        checks++;
        if (bus.PIN_incorrecto !== 1'b1 || bus.Advertencia !== 1'b0 || bus.Estado !== 2'd1) begin
            errors++;
            $display("FAIL wrong1: got pinc=%b adv=%b estado=%0d, required 1 0 1",
                     bus.PIN_incorrecto, bus.Advertencia, bus.Estado);
        end
        end_session;
        insert_card;
        enter_pin(16'h5555);
        tick;
        checks++;
        if (bus.PIN_incorrecto !== 1'b1 || bus.Advertencia !== 1'b1 || bus.Bloqueo !== 1'b0) begin
            errors++;
            $display("FAIL wrong2_adv: got pinc=%b adv=%b bloq=%b, required 1 1 0",
                     bus.PIN_incorrecto, bus.Advertencia, bus.Bloqueo);
        end
        enter_pin(16'h1234);
        tick;
        checks++;
        if (bus.Estado !== 2'd2 || bus.Advertencia !== 1'b0) begin
            errors++;
            $display("FAIL adv_clear: got estado=%0d adv=%b, required 2 0", bus.Estado, bus.Advertencia);
        end
        end_session;
        insert_card;
        for (int k = 1; k <= MAXI; k++) begin
            enter_pin(16'h5555);
            tick;
            checks++;
            if (bus.PIN_incorrecto !== 1'b1 || bus.Advertencia !== (k >= ADV) ||
                bus.Bloqueo !== (k >= MAXI) || bus.Estado !== ((k >= MAXI) ? 2'd3 : 2'd1)) begin
                errors++;
                $display("FAIL lock_seq%0d: got pinc=%b adv=%b bloq=%b estado=%0d", k,
                         bus.PIN_incorrecto, bus.Advertencia, bus.Bloqueo, bus.Estado);
            end
        end
        tick;
        insert_card;
        enter_pin(16'h1234);
        bus.Monto = 100;
        bus.Monto_STB = 1'b1;
        tick;
        bus.Monto_STB = 1'b0;
        tick;
        checks++;
        if (bus.Estado !== 2'd3 || bus.Bloqueo !== 1'b1 || bus.PIN_incorrecto !== 1'b0 || n_pinc != base + 5) begin
            errors++;
            $display("FAIL locked_stays: got estado=%0d bloq=%b pinc_pulses=%0d, required 3 1 %0d",
                     bus.Estado, bus.Bloqueo, n_pinc - base, 5);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_bal = '0;
        m_ret = '0;
        checks++;
        if (bus.Estado !== 2'd0 || bus.Bloqueo !== 1'b0 || bus.Advertencia !== 1'b0 || bus.Balance !== '0) begin
            errors++;
            $display("FAIL unlock_reset: got estado=%0d bloq=%b adv=%b balance=%0d, required 0 0 0 0",
                     bus.Estado, bus.Bloqueo, bus.Advertencia, bus.Balance);
        end
    endtask

    task automatic test_reset_mid;
        int ent0;
        open_session;
        do_tx(1'b0, 1000, 1'b0);
        drain;
        ent0 = n_ent;
        bus.Tipo_trans = 1'b1;
        bus.Monto = 200;
        bus.Monto_STB = 1'b1;
        rst = 1'b1;
        tick;
        bus.Monto_STB = 1'b0;
        m_bal = '0;
        checks++;
        if (bus.Balance !== '0 || bus.Entregar_dinero !== 1'b0 || bus.Estado !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_tx: got balance=%0d entregar=%b estado=%0d, required 0 0 0",
                     bus.Balance, bus.Entregar_dinero, bus.Estado);
        end
        rst = 1'b0;
        drain;
        checks++;
        if (n_ent != ent0) begin
            errors++;
            $display("FAIL reset_no_dispense: got %0d extra entregar pulses, required 0", n_ent - ent0);
        end
    endtask

    initial begin
        bus.Tarjeta_recibida = 1'b0;
        bus.Fin_sesion       = 1'b0;
        bus.PIN              = 16'h1234;
        bus.Digito           = 4'd0;
        bus.Digito_STB       = 1'b0;
        bus.Tipo_trans       = 1'b0;
        bus.Monto            = '0;
        bus.Monto_STB        = 1'b0;
        test_reset;
        test_pin_ok;
        test_limit;
        test_back_to_back;
        test_timeout;
        test_lock;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cajero_param.md
CAJERO_PARAM -- requirements
Module: cajero_param

Interface
REQ-001 SHALL take parameter PIN_DIGITS, default 4, number of BCD digits per PIN (1..8).
REQ-002 SHALL take parameter MONTO_W, default 32, width of the amount bus.
REQ-003 SHALL take parameter BAL_W, default 64, width of the balance register (BAL_W >= MONTO_W+1).
REQ-004 SHALL take parameter ADV_INTENTOS, default 2, number of wrong-PIN attempts that raises Advertencia.
REQ-005 SHALL take parameter MAX_INTENTOS, default 3, number of wrong-PIN attempts that locks the card (> ADV_INTENTOS).
REQ-006 SHALL take parameter LIMITE_RETIRO, default 10000, maximum cumulative withdrawal per card session.
REQ-007 SHALL take parameter TIMEOUT_CYC, default 1000, idle cycles before a session is aborted.
REQ-008 SHALL have ports: CLK in 1, single clock; Reset in 1, synchronous, active-high.
REQ-009 SHALL have ports: Tarjeta_recibida in 1; Fin_sesion in 1; PIN in 4*PIN_DIGITS, stored PIN; Digito in 4; Digito_STB in 1.
REQ-010 SHALL have ports: Tipo_trans in 1 (0 deposit, 1 withdraw); Monto in MONTO_W; Monto_STB in 1.
REQ-011 SHALL have outputs: Balance_actualizado, Entregar_dinero, Fondos_insuficientes, Limite_excedido, PIN_incorrecto, each 1-bit single-cycle pulse.
REQ-012 SHALL have outputs: Advertencia 1, level; Bloqueo 1, level; Balance out BAL_W; Estado out 2.

Function
REQ-013 SHALL implement states ESPERA_TARJETA=0, INGRESO_PIN=1, SESION=2, BLOQUEADO=3, visible on Estado, all outputs registered.
REQ-014 ESPERA_TARJETA: Tarjeta_recibida=1 -> INGRESO_PIN, digit counter and shift register cleared; if Bloqueo=1, go to BLOQUEADO instead.
REQ-015 INGRESO_PIN: each Digito_STB shifts Digito into the low nibble of a 4*PIN_DIGITS shift register and increments the digit counter; Digito values 10..15 are accepted raw.
REQ-016 On the strobe of digit PIN_DIGITS, compare occurs the next cycle: match -> SESION, attempt counter cleared, Advertencia cleared; mismatch -> PIN_incorrecto pulse, attempt counter +1, digit counter cleared, stay INGRESO_PIN.
REQ-017 Attempt counter reaching ADV_INTENTOS SHALL set Advertencia; reaching MAX_INTENTOS SHALL set Bloqueo and go to BLOQUEADO in the same cycle as the PIN_incorrecto pulse.
REQ-018 Attempt counter, Advertencia and Bloqueo SHALL persist across card sessions; only Reset or a correct PIN (counter, Advertencia) clears them.
REQ-019 BLOQUEADO: all strobes ignored; exit only via Reset.
REQ-020 SESION: Monto_STB with Monto=0 ignored; otherwise Tipo_trans sampled with Monto_STB, result pulses one cycle later.
REQ-021 Deposit: Balance += Monto saturating at 2^BAL_W-1; Balance_actualizado pulse.
REQ-022 Withdraw: if Monto > Balance -> Fondos_insuficientes pulse; else if retirado_sesion + Monto > LIMITE_RETIRO -> Limite_excedido pulse; else Balance -= Monto, retirado_sesion += Monto, Balance_actualizado and Entregar_dinero pulse together; Fondos_insuficientes takes priority.
REQ-023 Monto_STB on consecutive cycles SHALL each be processed; no strobe is dropped.
REQ-024 Fin_sesion in SESION or INGRESO_PIN -> ESPERA_TARJETA next cycle, retirado_sesion cleared; a Monto_STB in the same cycle is processed first.
REQ-025 Idle counter SHALL count in INGRESO_PIN and SESION, reset on any strobe or state entry; reaching TIMEOUT_CYC -> ESPERA_TARJETA, partial PIN discarded, attempt counter unchanged.
REQ-026 Digito_STB outside INGRESO_PIN and Monto_STB outside SESION SHALL be ignored.
REQ-027 Balance SHALL persist across sessions and be visible continuously on Balance.

Reset
REQ-028 Reset=1 at a CLK edge SHALL force ESPERA_TARJETA, Balance=0, attempt counter=0, retirado_sesion=0, idle counter=0, shift register=0, and every output 0, regardless of state.
REQ-029 Reset mid-transaction SHALL cancel any pending pulse; Reset has priority over all inputs.

Verification
REQ-030 PIN=16'h1234, card, digits 1,2,3,4 -> Estado=2 two cycles after last strobe, PIN_incorrecto never high.
REQ-031 Three wrong PINs (5,5,5,5) -> PIN_incorrecto pulses x3, Advertencia=1 after second, Bloqueo=1 and Estado=3 after third; new card -> stays BLOQUEADO until Reset.
REQ-032 Deposit 500, withdraw 200 -> Balance=300, Entregar_dinero one pulse; withdraw 400 -> Fondos_insuficientes, Balance=300.
REQ-033 Balance 20000, LIMITE_RETIRO=10000: withdraw 6000 ok, withdraw 5000 -> Limite_excedido; Fin_sesion, new session, withdraw 5000 ok, Balance=9000.
REQ-034 Session idle TIMEOUT_CYC cycles -> Estado=0; Reset asserted during withdraw strobe -> Balance=0, no Entregar_dinero pulse.
